// File: rtl/core_ctrl_pkg.sv
// Shared constants for the control sequencer: decoder instruction classes,
// access sizes and the sequencer state encoding.
package core_ctrl_pkg;

    localparam logic [3:0] INST_ILL   = 4'd0;
    localparam logic [3:0] INST_IMM   = 4'd1;
    localparam logic [3:0] INST_REG   = 4'd2;
    localparam logic [3:0] INST_UPP   = 4'd3;
    localparam logic [3:0] INST_JUMP  = 4'd4;
    localparam logic [3:0] INST_LOAD  = 4'd5;
    localparam logic [3:0] INST_STORE = 4'd6;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } ctrl_state_t;

    // Halves need an even address, words a 4-byte aligned one; bytes never fault.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/core_ctrl_lsu_align.sv
// Byte-lane alignment: store data replication and mask shift, plus load
// lane select with sign or zero extension.
module lsu_align
    import core_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      mem_size,
    input  logic            is_mem_sign,
    input  logic [3:0]      mem_wbmask,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      wmask,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wmask    = mem_wbmask << addr_lo;
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

        case (mem_size)
            SIZE_BYTE: wdata = {(XLEN/8){rs2_data[7:0]}};
            SIZE_HALF: wdata = {(XLEN/16){rs2_data[15:0]}};
            default:   wdata = rs2_data;
        endcase

        case (mem_size)
            SIZE_BYTE: load_data = {{(XLEN-8){is_mem_sign & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{(XLEN-16){is_mem_sign & half_sel[15]}}, half_sel};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle control sequencer: owns PC and instruction register, shares
// one bus port between fetch and load/store, and strobes register write-back.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wmask,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic [XLEN-1:0] inst,
    input  logic [3:0]      inst_type,
    input  logic [3:0]      mem_wbmask,
    input  logic [1:0]      mem_size,
    input  logic            is_mem_sign,
    input  logic [XLEN-1:0] alu_res,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc,
    output logic            reg_we,
    output logic            wb_sel,
    output logic [XLEN-1:0] load_data,
    output logic            halted,
    output logic            misalign
);

    ctrl_state_t     state, state_next;
    logic [1:0]      addr_lo, addr_lo_next, align_lo;
    logic [XLEN-1:0] pc_next, inst_next, addr_next, wdata_next, load_next;
    logic [XLEN-1:0] align_wdata, align_load;
    logic [3:0]      wmask_next, align_wmask;
    logic            req_next, we_next, halted_next, misalign_next, retire;

    // Stores align against the live ALU address in EXEC; loads use the latched one.
    assign align_lo = (state == ST_EXEC) ? alu_res[1:0] : addr_lo;

    lsu_align #(.XLEN(XLEN)) u_lsu_align (
        .addr_lo     (align_lo),
        .mem_size    (mem_size),
        .is_mem_sign (is_mem_sign),
        .mem_wbmask  (mem_wbmask),
        .rs2_data    (rs2_data),
        .rdata       (bus_rdata),
        .wdata       (align_wdata),
        .wmask       (align_wmask),
        .load_data   (align_load)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            inst      <= XLEN'(NOP_INST);
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= 4'b0000;
            load_data <= '0;
            halted    <= 1'b0;
            misalign  <= 1'b0;
            addr_lo   <= 2'b00;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            inst      <= inst_next;
            bus_req   <= req_next;
            bus_we    <= we_next;
            bus_addr  <= addr_next;
            bus_wdata <= wdata_next;
            bus_wmask <= wmask_next;
            load_data <= load_next;
            halted    <= halted_next;
            misalign  <= misalign_next;
            addr_lo   <= addr_lo_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        inst_next     = inst;
        req_next      = bus_req;
        we_next       = bus_we;
        addr_next     = bus_addr;
        wdata_next    = bus_wdata;
        wmask_next    = bus_wmask;
        load_next     = load_data;
        halted_next   = halted;
        misalign_next = misalign;
        addr_lo_next  = addr_lo;
        reg_we        = 1'b0;
        wb_sel        = 1'b0;
        retire        = 1'b0;

        case (state)
            ST_FETCH: begin
                if (!bus_req) begin
                    req_next  = 1'b1;
                    we_next   = 1'b0;
                    addr_next = pc;
                end else if (bus_ack) begin
                    inst_next  = bus_rdata;
                    req_next   = 1'b0;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (inst_type)
                    INST_IMM, INST_REG, INST_UPP, INST_JUMP: begin
                        reg_we = 1'b1;
                        retire = 1'b1;
                    end
                    INST_LOAD, INST_STORE: begin
                        addr_lo_next = alu_res[1:0];
                        if (is_misaligned(mem_size, alu_res[1:0])) begin
                            halted_next   = 1'b1;
                            misalign_next = 1'b1;
                            state_next    = ST_HALT;
                        end else begin
                            req_next   = 1'b1;
                            we_next    = (inst_type == INST_STORE);
                            addr_next  = {alu_res[XLEN-1:2], 2'b00};
                            wdata_next = (inst_type == INST_STORE) ? align_wdata : '0;
                            wmask_next = (inst_type == INST_STORE) ? align_wmask : 4'b0000;
                            state_next = ST_MEM;
                        end
                    end
                    default: begin
                        halted_next = 1'b1;
                        state_next  = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                if (bus_ack) begin
                    if (bus_we) begin
                        retire = 1'b1;
                    end else begin
                        load_next  = align_load;
                        req_next   = 1'b0;
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                wb_sel = 1'b1;
                retire = 1'b1;
            end
            ST_HALT: begin
                req_next = 1'b0;
            end
            default: begin
                req_next   = 1'b0;
                state_next = ST_HALT;
            end
        endcase

        // Retiring moves to the next PC and issues its fetch on the same edge.
        if (retire) begin
            pc_next    = next_pc;
            req_next   = 1'b1;
            we_next    = 1'b0;
            addr_next  = next_pc;
            wdata_next = '0;
            wmask_next = 4'b0000;
            state_next = ST_FETCH;
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: the bench plays bus slave and decoder,
// using hand-computed vectors, directed reset sequences and random traffic.
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bus_req, bus_we, bus_ack = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = 32'h0;
    logic [3:0]  bus_wmask;
    logic [31:0] inst;
    logic [3:0]  inst_type = 4'h0, mem_wbmask = 4'h0;
    logic [1:0]  mem_size = 2'b00;
    logic        is_mem_sign = 1'b0;
    logic [31:0] alu_res = 32'h0, rs2_data = 32'h0, next_pc = 32'h0;
    logic [31:0] pc, load_data;
    logic        reg_we, wb_sel, halted, misalign;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_pc;

    typedef struct {
        logic [3:0]  itype;
        logic [1:0]  size;
        logic        sign;
        logic [3:0]  wbmask;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [31:0] npc_off;
        int          waits;
        logic [31:0] word;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_load;
        logic        exp_halt;
        logic        exp_mis;
    } vec_t;

    vec_t table_v[15];

    core_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wmask   (bus_wmask),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .inst        (inst),
        .inst_type   (inst_type),
        .mem_wbmask  (mem_wbmask),
        .mem_size    (mem_size),
        .is_mem_sign (is_mem_sign),
        .alu_res     (alu_res),
        .rs2_data    (rs2_data),
        .next_pc     (next_pc),
        .pc          (pc),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .load_data   (load_data),
        .halted      (halted),
        .misalign    (misalign)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference behaviour from the access rules, using plain integer arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   m;
        int     lo;
        longint val;
        m = v;
        lo = int'(v.alu % 32'd4);
        m.exp_halt = 1'b0;
        m.exp_mis = 1'b0;
        m.exp_wdata = 32'h0;
        m.exp_wmask = 4'h0;
        m.exp_load = 32'h0;
        if (v.itype == INST_LOAD || v.itype == INST_STORE) begin
            if ((v.size == 2'd1 && lo % 2 != 0) || (v.size == 2'd2 && lo != 0)) begin
                m.exp_halt = 1'b1;
                m.exp_mis = 1'b1;
            end
        end else if (!(v.itype inside {INST_IMM, INST_REG, INST_UPP, INST_JUMP})) begin
            m.exp_halt = 1'b1;
        end
        m.exp_wmask = 4'((int'(v.wbmask) << lo) & 15);
        case (v.size)
            2'd0:    m.exp_wdata = (v.rs2 & 32'hFF) * 32'h0101_0101;
            2'd1:    m.exp_wdata = (v.rs2 & 32'hFFFF) * 32'h0001_0001;
            default: m.exp_wdata = v.rs2;
        endcase
        case (v.size)
            2'd0: begin
                val = longint'((v.rdata >> (8 * lo)) & 32'hFF);
                if (v.sign && val >= 128) val = val - 256;
                m.exp_load = 32'(val);
            end
            2'd1: begin
                val = longint'((v.rdata >> (16 * (lo / 2))) & 32'hFFFF);
                if (v.sign && val >= 32768) val = val - 65536;
                m.exp_load = 32'(val);
            end
            default: m.exp_load = v.rdata;
        endcase
        return m;
    endfunction

    function automatic vec_t random_vec();
        vec_t v;
        int   r;
        r = $urandom_range(0, 99);
        if (r < 3)       v.itype = INST_ILL;
        else if (r < 40) v.itype = 4'($urandom_range(1, 4));
        else if (r < 70) v.itype = INST_LOAD;
        else             v.itype = INST_STORE;
        v.size = 2'($urandom_range(0, 2));
        v.sign = 1'($urandom_range(0, 1));
        v.wbmask = (v.size == 2'd0) ? 4'h1 : (v.size == 2'd1) ? 4'h3 : 4'hF;
        v.alu = $urandom;
        if ($urandom_range(0, 3) != 0)
            v.alu = v.alu & ((v.size == 2'd2) ? 32'hFFFF_FFFC : (v.size == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
        v.rs2 = $urandom;
        v.rdata = $urandom;
        v.word = $urandom;
        v.npc_off = (v.itype == INST_JUMP) ? ($urandom & 32'h0000_0FFC) : 32'd4;
        v.waits = $urandom_range(0, 2);
        return model(v);
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        bus_ack = 1'b0;
        #1;
        check_output("rst_pc", pc, RST_PC);
        check_output("rst_inst", inst, NOP_INST);
        check_output("rst_bus_req", bus_req, 32'd0);
        check_output("rst_bus_we", bus_we, 32'd0);
        check_output("rst_bus_addr", bus_addr, 32'd0);
        check_output("rst_bus_wdata", bus_wdata, 32'd0);
        check_output("rst_bus_wmask", bus_wmask, 32'd0);
        check_output("rst_reg_we", reg_we, 32'd0);
        check_output("rst_wb_sel", wb_sel, 32'd0);
        check_output("rst_load_data", load_data, 32'd0);
        check_output("rst_halted", halted, 32'd0);
        check_output("rst_misalign", misalign, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_output("post_rst_req", bus_req, 32'd1);
        check_output("post_rst_addr", bus_addr, RST_PC);
        model_pc = RST_PC;
    endtask

    // Runs one instruction from its fetch; entered at a negedge with the fetch request up.
    task automatic apply_stimulus(input vec_t v);
        logic [31:0] npc, maddr;
        bit          is_alu, is_store;
        npc = model_pc + v.npc_off;
        maddr = v.alu & 32'hFFFF_FFFC;
        is_alu = v.itype inside {INST_IMM, INST_REG, INST_UPP, INST_JUMP};
        is_store = (v.itype == INST_STORE);
        for (int w = 0; w <= v.waits; w++) begin
            check_output("fetch_req", bus_req, 32'd1);
            check_output("fetch_we", bus_we, 32'd0);
            check_output("fetch_addr", bus_addr, model_pc);
            bus_ack = (w == v.waits);
            bus_rdata = (w == v.waits) ? v.word : $urandom;
            if (w == v.waits) begin
                inst_type = v.itype;
                mem_size = v.size;
                is_mem_sign = v.sign;
                mem_wbmask = v.wbmask;
                alu_res = v.alu;
                rs2_data = v.rs2;
                next_pc = npc;
            end
            @(negedge clock);
        end
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        check_output("exec_inst", inst, v.word);
        check_output("exec_req_low", bus_req, 32'd0);
        if (is_alu) begin
            check_output("exec_reg_we", reg_we, 32'd1);
            check_output("exec_wb_sel", wb_sel, 32'd0);
            @(negedge clock);
            check_output("alu_we_low", reg_we, 32'd0);
            check_output("alu_pc", pc, npc);
            model_pc = npc;
        end else if (v.exp_halt) begin
            check_output("halt_exec_we", reg_we, 32'd0);
            @(negedge clock);
            check_output("halt_flag", halted, 32'd1);
            check_output("halt_misalign", misalign, {31'd0, v.exp_mis});
            bus_ack = 1'b1;
            for (int i = 0; i < 3; i++) begin
                check_output("halt_no_req", bus_req, 32'd0);
                check_output("halt_no_we", reg_we, 32'd0);
                check_output("halt_pc", pc, model_pc);
                @(negedge clock);
            end
            bus_ack = 1'b0;
        end else begin
            check_output("mem_exec_we", reg_we, 32'd0);
            @(negedge clock);
            for (int w = 0; w <= v.waits; w++) begin
                check_output("mem_req", bus_req, 32'd1);
                check_output("mem_bus_we", bus_we, {31'd0, is_store});
                check_output("mem_addr", bus_addr, maddr);
                if (is_store) begin
                    check_output("mem_wdata", bus_wdata, v.exp_wdata);
                    check_output("mem_wmask", bus_wmask, {28'd0, v.exp_wmask});
                end
                bus_ack = (w == v.waits);
                bus_rdata = (w == v.waits) ? v.rdata : $urandom;
                @(negedge clock);
            end
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (is_store) begin
                check_output("store_pc", pc, npc);
                check_output("store_no_we", reg_we, 32'd0);
            end else begin
                check_output("wb_reg_we", reg_we, 32'd1);
                check_output("wb_sel", wb_sel, 32'd1);
                check_output("wb_load_data", load_data, v.exp_load);
                check_output("wb_req_low", bus_req, 32'd0);
                @(negedge clock);
                check_output("load_pc", pc, npc);
                check_output("load_we_low", reg_we, 32'd0);
            end
            model_pc = npc;
        end
    endtask

    initial begin
        vec_t rv;
        //              itype       sz    sg    wbm    alu           rs2           rdata         npc_off  w  word          exp_wdata     exp_wmask exp_load      halt  mis
        table_v[0]  = '{INST_IMM,   2'd0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        32'd4,   0, 32'h0050_0093, 32'h0,        4'h0,   32'h0,        1'b0, 1'b0};
        table_v[1]  = '{INST_LOAD,  2'd0, 1'b1, 4'h1, 32'h1000_0003, 32'h0,       32'h80AA_BBCC, 32'd4,  1, 32'h0030_8083, 32'h0,        4'h0,   32'hFFFF_FF80, 1'b0, 1'b0};
        table_v[2]  = '{INST_LOAD,  2'd1, 1'b0, 4'h3, 32'h1000_0002, 32'h0,       32'h8001_1234, 32'd4,  0, 32'h0020_D083, 32'h0,        4'h0,   32'h0000_8001, 1'b0, 1'b0};
        table_v[3]  = '{INST_STORE, 2'd0, 1'b0, 4'h1, 32'h2000_0001, 32'h0000_00A5, 32'h0,      32'd4,   3, 32'h0011_00A3, 32'hA5A5_A5A5, 4'h2,  32'h0,        1'b0, 1'b0};
        table_v[4]  = '{INST_STORE, 2'd1, 1'b0, 4'h3, 32'h2000_0002, 32'h1234_BEEF, 32'h0,      32'd4,   0, 32'h0011_1123, 32'hBEEF_BEEF, 4'hC,  32'h0,        1'b0, 1'b0};
        table_v[5]  = '{INST_STORE, 2'd2, 1'b0, 4'hF, 32'h2000_0000, 32'hDEAD_BEEF, 32'h0,      32'd4,   1, 32'h0011_2023, 32'hDEAD_BEEF, 4'hF,  32'h0,        1'b0, 1'b0};
        table_v[6]  = '{INST_LOAD,  2'd1, 1'b1, 4'h3, 32'h1000_0000, 32'h0,       32'h0000_8001, 32'd4,  0, 32'h0000_9083, 32'h0,        4'h0,   32'hFFFF_8001, 1'b0, 1'b0};
        table_v[7]  = '{INST_LOAD,  2'd0, 1'b0, 4'h1, 32'h1000_0001, 32'h0,       32'h1234_F056, 32'd4,  2, 32'h0010_C083, 32'h0,        4'h0,   32'h0000_00F0, 1'b0, 1'b0};
        table_v[8]  = '{INST_JUMP,  2'd0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h100, 0, 32'h1000_00EF, 32'h0,        4'h0,   32'h0,        1'b0, 1'b0};
        table_v[9]  = '{INST_REG,   2'd0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        32'd4,   2, 32'h0020_80B3, 32'h0,        4'h0,   32'h0,        1'b0, 1'b0};
        table_v[10] = '{INST_LOAD,  2'd2, 1'b1, 4'hF, 32'h1000_0004, 32'h0,       32'hCAFE_F00D, 32'd4,  0, 32'h0040_2083, 32'h0,        4'h0,   32'hCAFE_F00D, 1'b0, 1'b0};
        table_v[11] = '{INST_UPP,   2'd0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        32'd4,   1, 32'h1234_50B7, 32'h0,        4'h0,   32'h0,        1'b0, 1'b0};
        table_v[12] = '{INST_LOAD,  2'd2, 1'b0, 4'hF, 32'h1000_0002, 32'h0,       32'h0,        32'd4,   0, 32'h0020_2083, 32'h0,        4'h0,   32'h0,        1'b1, 1'b1};
        table_v[13] = '{INST_ILL,   2'd0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        32'd4,   0, 32'h0000_0073, 32'h0,        4'h0,   32'h0,        1'b1, 1'b0};
        table_v[14] = '{INST_STORE, 2'd1, 1'b0, 4'h3, 32'h2000_0003, 32'h0,       32'h0,        32'd4,   1, 32'h0011_11A3, 32'h0,        4'h0,   32'h0,        1'b1, 1'b1};

        #1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(table_v[i]);
            if (table_v[i].exp_halt) do_reset();
        end

        // Reset lands mid-fetch with an ack pending; the ack must not be taken.
        bus_ack = 1'b0;
        @(negedge clock);
        check_output("midfetch_req", bus_req, 32'd1);
        bus_ack = 1'b1;
        bus_rdata = 32'hBAD0_0BAD;
        #2;
        reset = 1'b0;
        #1;
        check_output("midfetch_req_drop", bus_req, 32'd0);
        check_output("midfetch_pc", pc, RST_PC);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        bus_ack = 1'b0;
        check_output("late_ack_req", bus_req, 32'd1);
        check_output("late_ack_inst", inst, NOP_INST);
        check_output("late_ack_addr", bus_addr, RST_PC);
        model_pc = RST_PC;
        apply_stimulus(table_v[0]);

        for (int i = 0; i < 250; i++) begin
            rv = random_vec();
            apply_stimulus(rv);
            if (rv.exp_halt) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
